// File: rtl/adder_if_pkg.sv
// Shared widths and types for the handshaked adder block.
package adder_if_pkg;

    localparam int ADD_W_DEFAULT = 4;
    localparam int CNT_W         = 16;

    typedef logic [ADD_W_DEFAULT-1:0] operand_t;
    typedef logic [ADD_W_DEFAULT:0]   sum_t;

    // Zero-extended add at the default width; the MSB of the result is the carry.
    function automatic sum_t add_ext(input operand_t x, input operand_t y);
        return {1'b0, x} + {1'b0, y};
    endfunction

endpackage

// File: rtl/adder_if_unit_if.sv
// Operand-in / sum-out handshake bundle. The master drives operands and
// accepts results; the slave is the adder unit.
interface adder_if_unit_if
    import adder_if_pkg::*;
#(
    parameter int W = ADD_W_DEFAULT
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out;
    logic         carry;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, carry
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, carry
    );

endinterface

// File: rtl/adder_if_unit_core.sv
// Pure combinational widening adder: the sum is one bit wider than the
// operands so it can never overflow.
module adder_core
    import adder_if_pkg::*;
#(
    parameter int W = ADD_W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);

    // Extend both operands before adding so the carry lands in sum[W].
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/adder_if_unit.sv
// Registered adder with valid/ready on both sides. A single output register
// stage gives one-cycle latency and full throughput: a new sum can be loaded
// in the same edge the old one is handed off.
module adder_if_unit
    import adder_if_pkg::*;
#(
    parameter int W = ADD_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_if_unit_if.slave   bus,
    output logic [CNT_W-1:0] txn_count
);

    logic [W:0]       sum_next;
    logic [W:0]       out_reg;
    logic             carry_reg;
    logic             out_valid_reg;
    logic [CNT_W-1:0] txn_count_reg;
    logic             accept;
    logic             xfer;

    adder_core #(.W(W)) u_core (
        .a   (bus.a),
        .b   (bus.b),
        .sum (sum_next)
    );

    // Ready whenever the output slot is empty or is being drained this edge;
    // held low while reset is asserted.
    assign bus.in_ready = rst_n && (!out_valid_reg || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = out_valid_reg && bus.out_ready;

    // Output register: load on accept, otherwise hold the last sum (not cleared on drain).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg       <= '0;
            carry_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                out_reg   <= sum_next;
                carry_reg <= sum_next[W];
            end
            if (accept) begin
                out_valid_reg <= 1'b1;
            end else if (xfer) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // Completed output transfers, wrapping naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count_reg <= '0;
        end else if (xfer) begin
            txn_count_reg <= txn_count_reg + 1'b1;
        end
    end

    assign bus.out       = out_reg;
    assign bus.carry     = carry_reg;
    assign bus.out_valid = out_valid_reg;
    assign txn_count     = txn_count_reg;

endmodule

// File: tb/tb_adder_if_unit.sv
// Scoreboard bench for adder_if_unit: sums are queued on accept and popped
// on each output transfer; a cycle model tracks valid/ready/out/count.
module tb_adder_if_unit;
    import adder_if_pkg::*;

    localparam int W = ADD_W_DEFAULT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] txn_count;

    adder_if_unit_if #(.W(W)) bus ();

    adder_if_unit #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;
    bit quiet   = 1'b0;

    sum_t             exp_q[$];
    sum_t             m_out   = '0;
    logic             m_valid = 1'b0;
    logic [CNT_W-1:0] m_cnt   = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus just after a rising edge.
    task automatic drive(input logic v, input operand_t av, input operand_t bv, input logic r);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.a         = av;
        bus.b         = bv;
        bus.out_ready = r;
    endtask

    // Monitor and model, sampled on the falling edge.
    initial begin
        sum_t popped;
        logic m_ready;
        logic acc;
        logic xf;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
                check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
                check_val("rst_out", 32'(bus.out), 32'd0);
                check_val("rst_txn", 32'(txn_count), 32'd0);
                exp_q.delete();
                m_out   = '0;
                m_valid = 1'b0;
                m_cnt   = '0;
            end else begin
                m_ready = !m_valid || bus.out_ready;
                check_val("out_valid", 32'(bus.out_valid), 32'(m_valid));
                check_val("in_ready", 32'(bus.in_ready), 32'(m_ready));
                check_val("out_hold", 32'(bus.out), 32'(m_out));
                check_val("carry", 32'(bus.carry), 32'(m_out[W]));
                check_val("txn_count", 32'(txn_count), 32'(m_cnt));
                xf  = m_valid && bus.out_ready;
                acc = bus.in_valid && m_ready;
                if (xf) begin
                    if (exp_q.size() == 0) begin
                        check_val("sb_empty", 32'd1, 32'd0);
                    end else begin
                        popped = exp_q.pop_front();
                        check_val("sb_sum", 32'(bus.out), 32'(popped));
                        if (!quiet)
                            $display("xfer: out=0x%0h carry=%0d expected=0x%0h count=%0d",
                                     bus.out, bus.carry, popped, m_cnt + 1'b1);
                    end
                    m_cnt = m_cnt + 1'b1;
                end
                if (acc) begin
                    m_out = {1'b0, bus.a} + {1'b0, bus.b};
                    exp_q.push_back(m_out);
                    if (!quiet)
                        $display("accept: a=%0d b=%0d", bus.a, bus.b);
                end
                if (acc)
                    m_valid = 1'b1;
                else if (xf)
                    m_valid = 1'b0;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check_val("init_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("init_out", 32'(bus.out), 32'd0);
        check_val("init_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("init_txn", 32'(txn_count), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_val("release_in_ready", 32'(bus.in_ready), 32'd1);

        // 3 + 4
        drive(1'b1, 4'd3, 4'd4, 1'b1);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        check_val("t1_out", 32'(bus.out), 32'd7);
        check_val("t1_valid", 32'(bus.out_valid), 32'd1);
        check_val("t1_carry", 32'(bus.carry), 32'd0);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        check_val("t1_txn", 32'(txn_count), 32'd1);
        check_val("t1_drained", 32'(bus.out_valid), 32'd0);
        check_val("t1_keep", 32'(bus.out), 32'd7);

        // Back-to-back (1,4) then (1,6)
        drive(1'b1, 4'd1, 4'd4, 1'b1);
        drive(1'b1, 4'd1, 4'd6, 1'b1);
        check_val("t2_out_a", 32'(bus.out), 32'd5);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        check_val("t2_out_b", 32'(bus.out), 32'd7);
        check_val("t2_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        check_val("t2_txn", 32'(txn_count), 32'd3);

        // 15 + 15 with carry
        drive(1'b1, 4'd15, 4'd15, 1'b1);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        check_val("t3_out", 32'(bus.out), 32'h1E);
        check_val("t3_carry", 32'(bus.carry), 32'd1);

        // Unknown operands with in_valid low must not reach out
        drive(1'b0, 'x, 'x, 1'b1);
        drive(1'b0, 'x, 'x, 1'b1);
        check_val("x_out", 32'(bus.out), 32'h1E);
        check_val("x_valid", 32'(bus.out_valid), 32'd0);

        // Stall: capture (2,2), hold for 3 cycles with (9,9) offered
        drive(1'b1, 4'd2, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd9, 4'd9, 1'b0);
            check_val("t4_hold", 32'(bus.out), 32'd4);
            check_val("t4_ready", 32'(bus.in_ready), 32'd0);
        end
        drive(1'b1, 4'd9, 4'd9, 1'b1);
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        check_val("t4_out", 32'(bus.out), 32'd18);
        check_val("t4_txn", 32'(txn_count), 32'd5);

        // Asynchronous reset in the middle of a stall
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t5_valid", 32'(bus.out_valid), 32'd0);
        check_val("t5_out", 32'(bus.out), 32'd0);
        check_val("t5_carry", 32'(bus.carry), 32'd0);
        check_val("t5_txn", 32'(txn_count), 32'd0);
        check_val("t5_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 4'd5, 4'd5, 1'b1);
        drive(1'b1, 4'd5, 4'd5, 1'b1);
        check_val("t5_no_capture", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        check_val("t5_release_ready", 32'(bus.in_ready), 32'd1);
        check_val("t5_release_txn", 32'(txn_count), 32'd0);

        // Full operand sweep, then random traffic up to 65535 transfers
        quiet = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, operand_t'(i >> 4), operand_t'(i), 1'b1);
        end
        for (int i = 256; i < 65535; i++) begin
            drive(1'b1, operand_t'($urandom), operand_t'($urandom), 1'b1);
        end
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        quiet = 1'b0;
        check_val("t6_txn_max", 32'(txn_count), 32'h0000_FFFF);
        drive(1'b1, 4'd7, 4'd8, 1'b1);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        check_val("t6_txn_wrap", 32'(txn_count), 32'd0);
        check_val("t6_out", 32'(bus.out), 32'd15);
        check_val("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/adder_if_unit.md
Name: adder_if_unit

Overview:
- Registered unsigned adder: two W-bit operands in, a (W+1)-bit sum out, where the MSB is the carry.
- Valid/ready handshake on both the input and output sides.
- Sits behind an operand-bundle interface and feeds a downstream consumer that may stall.
- Full throughput: one sum per clock when the consumer is not stalling.

Parameters:
- W, 4, operand width in bits; sum width is W+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a and b are valid this cycle
- in_ready  output  1  block can accept operands this cycle
- a  input  W  operand A, unsigned
- b  input  W  operand B, unsigned
- out_valid  output  1  out is valid
- out_ready  input  1  consumer accepts out this cycle
- out  output  W+1  registered sum a+b, zero-extended add, no truncation
- carry  output  1  equals out[W]; registered together with out
- txn_count  output  16  count of completed output transfers; wraps at 2^16

Behaviour:
- Reset (rst_n low, asynchronous):
  - out=0, carry=0, out_valid=0, txn_count=0.
  - in_ready=0 while rst_n is low.
  - Effect is immediate, without waiting for a clock edge.
- Release: first rising edge with rst_n high resumes normal operation; in_ready=1 in that cycle.
- Arithmetic: out = {1'b0,a} + {1'b0,b}, unsigned, never overflows W+1 bits; carry = out[W].
  - W=4 examples: 3+4=7, 1+4=5, 1+6=7, 15+15=30 (0x1E, carry=1).
- Input accept: when in_valid && in_ready at a rising edge, the sum is registered.
  - out_valid=1 from the next cycle (latency 1).
- in_ready (combinational) = rst_n && (!out_valid || out_ready).
- Output transfer: happens when out_valid && out_ready at a rising edge.
- Simultaneous transfer and accept in the same edge: new sum replaces old; out_valid stays 1; no bubble.
- Transfer with no accept: out_valid falls to 0 next cycle; out keeps its last value (not cleared).
- Stall (out_valid=1, out_ready=0):
  - out and carry hold stable.
  - in_ready=0; operands presented are not captured.
- txn_count: increments by 1 on each output transfer; 0xFFFF+1 wraps to 0.
- in_valid low: no capture, regardless of a/b changes; out must not follow a/b combinationally.
- Reset mid-operation: pending result is discarded, and all outputs take their reset values asynchronously.
- X on a/b while in_valid=0 must not propagate to out.

Decomposition:
- Shared package adder_if_pkg holds:
  - ADD_W_DEFAULT = 4
  - typedef operand_t = logic [W-1:0]
  - typedef sum_t = logic [W:0]
  - CNT_W = 16
- One combinational sub-module, adder_core (W param: a, b -> sum), instantiated once.
- Handshake, registers and counter live in the top.

Test Plan:
1. Reset, then in_valid=1 with a=3, b=4, out_ready=1 -> next cycle out=7, carry=0, out_valid=1, txn_count=1 one edge later.
2. Back-to-back in_valid with out_ready=1:
   - (1,4) then (1,6) -> out=5 then 7 on consecutive cycles; out_valid stays 1; txn_count +2.
3. a=15, b=15 -> out=0x1E, carry=1.
4. Stall:
   - Capture (2,2), then out_ready=0 for 3 cycles while in_valid=1 with (9,9) -> out holds 4, in_ready=0.
   - Raise out_ready -> (9,9) accepted; next out=18.
5. rst_n low asynchronously mid-stall with out_valid=1 -> out_valid, out, carry and txn_count go to 0 immediately; in_ready=0 until release.
6. Force txn_count to 0xFFFF via 65535 transfers, then one more transfer -> txn_count=0; random a/b sweep checks out=a+b for all 256 pairs.
